// File: rtl/dispatch_buffer_if.sv
// Bundle between rename/dispatch, the dispatch buffer and the issue queue.
// master drives the rename-side inputs; slave is the buffer itself.
interface dispatch_buffer_if #(
  parameter int WIDTH     = 33,
  parameter int WIDTH_BRM = 3
);
  logic [WIDTH-1:0]     i_inst1;
  logic [WIDTH-1:0]     i_inst2;
  logic [WIDTH-1:0]     i_inst3;
  logic [WIDTH-1:0]     i_inst4;
  logic                 i_we;
  logic [WIDTH_BRM-1:0] i_BrKill;
  logic                 i_stall;
  logic                 o_full;
  logic [WIDTH-1:0]     o_inst1;
  logic [WIDTH-1:0]     o_inst2;
  logic [WIDTH-1:0]     o_inst3;
  logic [WIDTH-1:0]     o_inst4;
  logic                 o_en;

  modport master (
    output i_inst1, i_inst2, i_inst3, i_inst4, i_we, i_BrKill, i_stall,
    input  o_full, o_inst1, o_inst2, o_inst3, o_inst4, o_en
  );

  modport slave (
    input  i_inst1, i_inst2, i_inst3, i_inst4, i_we, i_BrKill, i_stall,
    output o_full, o_inst1, o_inst2, o_inst3, o_inst4, o_en
  );
endinterface

// File: rtl/dispatch_buffer.sv
// Circular dispatch FIFO: compacts up to 4 live lanes per cycle, presents the
// oldest 4 entries to the issue queue, and squashes killed entries in place.
module dispatch_buffer #(
  parameter int DEPTH     = 16,
  parameter int WIDTH_REG = 5,
  parameter int WIDTH_TAG = 5,
  parameter int WIDTH_BRM = 3,
  parameter int WIDTH     = 7 + WIDTH_BRM + WIDTH_TAG + 3*WIDTH_REG + 3
) (
  input logic              i_clk,
  input logic              i_rst_n,
  dispatch_buffer_if.slave bus
);
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int BRM_LSB = WIDTH - 7 - WIDTH_BRM;

  // Storage drops the valid flag; the separately reset vld vector owns it.
  logic [WIDTH-2:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] lane [4];
  logic [WIDTH-1:0] out_word [4];
  logic [PW-1:0]    rd_idx [4];
  logic [PW-1:0]    wr_idx [4];
  logic [2:0]       off [4];
  logic [3:0]       live;
  logic [2:0]       npush;
  logic [2:0]       npush_eff;
  logic [2:0]       npop;
  logic             full;
  logic             push;
  logic             en;

  assign lane[0] = bus.i_inst1;
  assign lane[1] = bus.i_inst2;
  assign lane[2] = bus.i_inst3;
  assign lane[3] = bus.i_inst4;

  // Each live lane lands at tail plus the number of live lanes ahead of it.
  always_comb begin
    npush = '0;
    for (int k = 0; k < 4; k++) begin
      live[k]   = lane[k][0] && ((lane[k][BRM_LSB +: WIDTH_BRM] & bus.i_BrKill) == '0);
      off[k]    = npush;
      wr_idx[k] = tail + PW'(off[k]);
      npush     = npush + {2'b00, live[k]};
    end
  end

  assign full      = (CW'(DEPTH) - count) < CW'(4);
  assign push      = bus.i_we & ~full;
  assign en        = (count != '0) & ~bus.i_stall;
  assign npush_eff = push ? npush : 3'd0;
  assign npop      = !en ? 3'd0 : (count >= CW'(4)) ? 3'd4 : count[2:0];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_idx[k]   = head + PW'(k);
      out_word[k] = (count > CW'(k)) ? {mem[rd_idx[k]], vld[rd_idx[k]]} : '0;
    end
  end

  assign bus.o_inst1 = out_word[0];
  assign bus.o_inst2 = out_word[1];
  assign bus.o_inst3 = out_word[2];
  assign bus.o_inst4 = out_word[3];
  assign bus.o_full  = full;
  assign bus.o_en    = en;

  // Kill clears stored valid bits first; fresh pushes only touch free slots.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      vld   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if ((mem[i][BRM_LSB-1 +: WIDTH_BRM] & bus.i_BrKill) != '0) vld[i] <= 1'b0;
      if (push)
        for (int k = 0; k < 4; k++)
          if (live[k]) vld[wr_idx[k]] <= 1'b1;
      head  <= head + PW'(npop);
      tail  <= tail + PW'(npush_eff);
      count <= count + CW'(npush_eff) - CW'(npop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      for (int k = 0; k < 4; k++)
        if (live[k]) mem[wr_idx[k]] <= lane[k][WIDTH-1:1];
  end
endmodule

// File: tb/tb_dispatch_buffer.sv
// Bench for dispatch_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the buffer contents.
module tb_dispatch_buffer;
  localparam int W = 33;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [W-1:0] lane [4];
  logic       we = 1'b0;
  logic [2:0] kill = 3'b000;
  logic       stall = 1'b1;
  logic [W-1:0] got [4];

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] mq [$];

  always #5 clk = ~clk;

  dispatch_buffer_if #(.WIDTH(W), .WIDTH_BRM(3)) bus ();

  assign bus.i_inst1  = lane[0];
  assign bus.i_inst2  = lane[1];
  assign bus.i_inst3  = lane[2];
  assign bus.i_inst4  = lane[3];
  assign bus.i_we     = we;
  assign bus.i_BrKill = kill;
  assign bus.i_stall  = stall;
  assign got[0] = bus.o_inst1;
  assign got[1] = bus.o_inst2;
  assign got[2] = bus.o_inst3;
  assign got[3] = bus.o_inst4;

  dispatch_buffer #(.DEPTH(16)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  function automatic logic [W-1:0] mk(logic [2:0] brm, logic [4:0] tag, logic v);
    logic [6:0]  op;
    logic [14:0] regs;
    logic [1:0]  fl;
    op = 7'($urandom); regs = 15'($urandom); fl = 2'($urandom);
    return {op, brm, tag, regs, fl, v};
  endfunction

  function automatic logic [W-1:0] ew(int k);
    return (k < mq.size()) ? mq[k] : '0;
  endfunction

  function automatic logic exp_full();
    return (16 - mq.size()) < 4;
  endfunction

  function automatic logic exp_en();
    return (mq.size() != 0) && !stall;
  endfunction

  // Queue model: drop popped front, kill survivors, append live lanes.
  task automatic model_edge();
    logic [W-1:0] nq [$];
    logic [W-1:0] w;
    int np;
    logic fl;
    fl = exp_full();
    np = exp_en() ? ((mq.size() < 4) ? mq.size() : 4) : 0;
    for (int i = np; i < mq.size(); i++) begin
      w = mq[i];
      if ((w[25:23] & kill) != 3'b000) w[0] = 1'b0;
      nq.push_back(w);
    end
    if (we && !fl)
      for (int k = 0; k < 4; k++)
        if (lane[k][0] && ((lane[k][25:23] & kill) == 3'b000)) nq.push_back(lane[k]);
    mq = nq;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 4; k++) lane[k] = '0;
    we = 1'b0; kill = 3'b000; stall = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    mq.delete();
    @(negedge clk);
    #1;
  endtask

  task automatic push_n(int n, logic [4:0] tag0);
    for (int k = 0; k < 4; k++) lane[k] = (k < n) ? mk(3'b000, tag0 + 5'(k), 1'b1) : '0;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_inst%0d got %h want 0", k+1, got[k]);
      end
    end
    vectors++;
    if (bus.o_full !== 1'b0 || bus.o_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags got full=%b en=%b want 0 0", bus.o_full, bus.o_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    @(negedge clk);
    #1;
  endtask

  task automatic test_push4();
    push_n(4, 5'd1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k][22:18] !== 5'(k+1) || got[k][0] !== 1'b1 || got[k] !== ew(k)) begin
        miscompares++;
        $display("FAIL push4_inst%0d got %h want tag %0d word %h", k+1, got[k], k+1, ew(k));
      end
    end
    vectors++;
    if (bus.o_en !== 1'b0) begin
      miscompares++;
      $display("FAIL push4_en got %b want 0", bus.o_en);
    end
  endtask

  task automatic test_sparse();
    do_reset();
    lane[0] = mk(3'b000, 5'd5, 1'b1);
    lane[1] = mk(3'b000, 5'd6, 1'b0);
    lane[2] = mk(3'b000, 5'd7, 1'b1);
    lane[3] = mk(3'b000, 5'd8, 1'b0);
    we = 1'b1;
    tick();
    we = 1'b0;
    vectors++;
    if (got[0][22:18] !== 5'd5 || got[1][22:18] !== 5'd7 || got[0] !== ew(0) || got[1] !== ew(1)) begin
      miscompares++;
      $display("FAIL sparse_order got %h %h want tags 5 7", got[0], got[1]);
    end
    vectors++;
    if (got[2] !== '0 || got[3] !== '0) begin
      miscompares++;
      $display("FAIL sparse_tail got %h %h want 0 0", got[2], got[3]);
    end
  endtask

  task automatic test_fill();
    logic [W-1:0] snap [4];
    do_reset();
    push_n(4, 5'd0);
    push_n(4, 5'd4);
    push_n(4, 5'd8);
    vectors++;
    if (bus.o_full !== 1'b0) begin
      miscompares++;
      $display("FAIL fill12_full got %b want 0", bus.o_full);
    end
    push_n(1, 5'd12);
    vectors++;
    if (bus.o_full !== 1'b1) begin
      miscompares++;
      $display("FAIL fill13_full got %b want 1", bus.o_full);
    end
    for (int k = 0; k < 4; k++) snap[k] = got[k];
    push_n(4, 5'd20);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k] !== snap[k] || got[k] !== ew(k)) begin
        miscompares++;
        $display("FAIL fill_drop_inst%0d got %h want %h", k+1, got[k], snap[k]);
      end
    end
    vectors++;
    if (bus.o_full !== 1'b1 || mq.size() != 13) begin
      miscompares++;
      $display("FAIL fill_drop_full got %b want 1 (model %0d)", bus.o_full, mq.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    push_n(4, 5'd0);
    push_n(4, 5'd0);
    push_n(4, 5'd0);
    push_n(2, 5'd0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    stall = 1'b1;
    push_n(4, 5'd24);
    push_n(2, 5'd28);
    stall = 1'b0;
    push_n(4, 5'd16);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got[k][22:18] !== ((k < 2) ? 5'(28 + k) : 5'(14 + k)) || got[k] !== ew(k)) begin
        miscompares++;
        $display("FAIL wrap_inst%0d got %h want tag %0d", k+1, got[k], (k < 2) ? 28 + k : 14 + k);
      end
    end
    vectors++;
    if (bus.o_full !== 1'b0 || mq.size() != 6) begin
      miscompares++;
      $display("FAIL wrap_count got full=%b want 0 (model %0d)", bus.o_full, mq.size());
    end
  endtask

  task automatic test_kill();
    do_reset();
    lane[0] = mk(3'b010, 5'd3, 1'b1);
    lane[1] = mk(3'b100, 5'd4, 1'b1);
    we = 1'b1;
    tick();
    lane[0] = mk(3'b011, 5'd9, 1'b1);
    lane[1] = '0;
    kill = 3'b010;
    #1;
    vectors++;
    if (got[0][0] !== 1'b1) begin
      miscompares++;
      $display("FAIL kill_prekill got %b want 1", got[0][0]);
    end
    tick();
    we = 1'b0; kill = 3'b000;
    vectors++;
    if (got[0][0] !== 1'b0 || got[0][22:18] !== 5'd3 || got[0] !== ew(0)) begin
      miscompares++;
      $display("FAIL kill_hit got %h want tag 3 invalid", got[0]);
    end
    vectors++;
    if (got[1][0] !== 1'b1 || got[1][22:18] !== 5'd4 || got[2] !== '0) begin
      miscompares++;
      $display("FAIL kill_spare got %h %h want tag 4 valid then 0", got[1], got[2]);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push_n(4, 5'd0);
    push_n(4, 5'd4);
    push_n(1, 5'd8);
    stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (got[0] !== '0 || got[1] !== '0 || bus.o_en !== 1'b0 || bus.o_full !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got %h en=%b full=%b want 0", got[0], bus.o_en, bus.o_full);
    end
    mq.delete();
    #1;
    rst_n = 1'b1;
    stall = 1'b1;
    @(negedge clk);
    push_n(1, 5'd7);
    vectors++;
    if (got[0] !== ew(0) || got[0][22:18] !== 5'd7 || got[1] !== '0) begin
      miscompares++;
      $display("FAIL async_repush got %h %h want %h 0", got[0], got[1], ew(0));
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 4; k++)
        lane[k] = mk(($urandom % 3 == 0) ? 3'($urandom) : 3'b000, 5'($urandom), ($urandom % 4) != 0);
      kill  = ($urandom % 8 == 0) ? 3'($urandom) : 3'b000;
      stall = ($urandom % 3) == 0;
      we    = exp_full() ? ($urandom % 8 == 0) : ($urandom % 4 != 0);
      #1;
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (got[k] !== ew(k)) begin
          miscompares++;
          $display("FAIL rand_inst%0d cyc %0d got %h want %h", k+1, n, got[k], ew(k));
        end
      end
      vectors++;
      if (bus.o_full !== exp_full() || bus.o_en !== exp_en()) begin
        miscompares++;
        $display("FAIL rand_flags cyc %0d got full=%b en=%b want %b %b", n, bus.o_full, bus.o_en, exp_full(), exp_en());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) lane[k] = '0;
    test_reset();
    test_push4();
    test_sparse();
    test_fill();
    test_wrap();
    test_kill();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
